// File: rtl/cla_pkg.sv
// Shared constants and types for the arbitrated 64-bit adder.
package cla_pkg;

  localparam int DATA_W   = 64;
  // Stored id width; rsp_id exposes the low IDW bits.
  localparam int ID_MAX_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]   sum;
    logic                cout;
    logic [ID_MAX_W-1:0] id;
    logic                last;
  } rsp_t;

endpackage

// File: rtl/cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla64
  import cla_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W:0]   c;
  logic              gg;
  logic              pp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    gg   = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int j = 0; j < DATA_W / 4; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
           (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pp = &p[4*j +: 4];
      c[4*j+4] = gg | (pp & c[4*j]);
    end
    sum  = p ^ c[DATA_W-1:0];
    cout = c[DATA_W];
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning up from ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/cla64_arbiter.sv
// Round-robin arbiter sharing one cla64 among NREQ requesters, with multi-beat
// carry chaining and a one-entry registered response buffer.
module cla64_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  input  logic [NREQ-1:0]        req_last,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_last
);

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  owner_q;
  logic            carry_q;
  logic            rsp_valid_q;
  rsp_t            rsp_q;
  rsp_t            rsp_d;

  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  pick_ptr;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            can_acc;
  logic            accept;
  logic [IDW-1:0]  nxt_ptr;
  logic            add_cin;
  logic [DATA_W-1:0] add_sum;
  logic            add_cout;
  logic            unused_id;

  assign can_acc = !rsp_valid_q || rsp_ready;

  // While locked, only the owner may be picked; the picker starting at the owner grants it.
  always_comb begin
    elig     = req_valid;
    pick_ptr = rr_ptr_q;
    if (state_q == LOCKED) begin
      elig     = req_valid & (NREQ'(1) << owner_q);
      pick_ptr = owner_q;
    end
  end

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req  (elig),
    .ptr  (pick_ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign accept    = pick_any && can_acc && !rst;
  assign req_ready = accept ? pick_grant : '0;
  assign add_cin   = (state_q == LOCKED) ? carry_q : req_cin[pick_idx];
  assign nxt_ptr   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDW'(1);

  cla64 u_add (
    .a   (req_a[int'(pick_idx)*DATA_W +: DATA_W]),
    .b   (req_b[int'(pick_idx)*DATA_W +: DATA_W]),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    rsp_d      = '0;
    rsp_d.sum  = add_sum;
    rsp_d.cout = add_cout;
    rsp_d.id   = ID_MAX_W'(pick_idx);
    rsp_d.last = req_last[pick_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= 1'b1;
      if (rsp_d.last) begin
        state_q  <= IDLE;
        rr_ptr_q <= nxt_ptr;
        carry_q  <= 1'b0;
      end else begin
        state_q <= LOCKED;
        owner_q <= pick_idx;
        carry_q <= add_cout;
      end
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_id    = rsp_q.id[IDW-1:0];
  assign rsp_last  = rsp_q.last;
  assign unused_id = ^rsp_q.id;

endmodule
